// File: rtl/force_sched_pkg.sv
// force_sched_pkg: shared state encoding, default widths and owner-width helper
package force_sched_pkg;
    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;
    localparam int DURW_DEF  = 4;

    function automatic int ownw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int OWNW = ownw(NREQ_DEF);

    typedef enum logic [1:0] {IDLE, FORCE, GAP} state_t;
endpackage

// File: rtl/force_sched_if.sv
// force_sched_if: request/base inputs and override outputs of the scheduler
interface force_sched_if
    import force_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DURW  = DURW_DEF
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_val;
    logic [NREQ*DURW-1:0]  req_dur;
    logic [WIDTH-1:0]      base_d;
    logic                  base_we;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      out;
    logic                  forced;
    logic [ownw(NREQ)-1:0] owner;
    logic                  busy;
    logic [WIDTH-1:0]      base_q;

    modport master (
        output req, req_val, req_dur, base_d, base_we,
        input  gnt, out, forced, owner, busy, base_q
    );

    modport slave (
        input  req, req_val, req_dur, base_d, base_we,
        output gnt, out, forced, owner, busy, base_q
    );
endinterface

// File: rtl/force_sched_rr_arb.sv
// rr_arb: combinational round-robin pick starting the search at ptr
module rr_arb #(
    parameter int NREQ = 4,
    parameter int OW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [OW-1:0]   idx
);
    int j;

    // scan offsets from farthest to nearest so the requester closest to ptr wins last
    always_comb begin
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = (j >= NREQ) ? j - NREQ : j;
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                idx    = OW'(j);
            end
        end
    end
endmodule

// File: rtl/force_sched.sv
// force_sched: round-robin shared override of a registered base status value
module force_sched
    import force_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int DURW  = DURW_DEF
) (
    input  logic clk,
    input  logic rst,
    force_sched_if.slave bus
);
    localparam int OW = ownw(NREQ);

    state_t          state, state_n;
    logic [OW-1:0]   ptr, pick_idx, owner_q;
    logic [NREQ-1:0] pick_gnt, gnt_q;
    logic [WIDTH-1:0] val_q, base_r;
    logic [DURW-1:0] cnt, dur_w;
    logic            grant;

    rr_arb #(.NREQ(NREQ), .OW(OW)) u_arb (
        .req (bus.req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign grant = (state == IDLE) && |bus.req;
    assign dur_w = bus.req_dur[int'(pick_idx)*DURW +: DURW];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state: a grant starts FORCE, the last counted cycle drops into a single GAP
    always_comb begin
        state_n = (state == IDLE)  ? (|bus.req ? FORCE : IDLE) :
                  (state == FORCE) ? ((cnt <= DURW'(1)) ? GAP : FORCE) : IDLE;
    end

    // grant-time latches, duration counter, rotation pointer and grant pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q   <= '0;
            cnt     <= '0;
            ptr     <= '0;
            owner_q <= '0;
            gnt_q   <= '0;
        end else begin
            gnt_q <= grant ? pick_gnt : '0;
            if (grant) begin
                val_q   <= bus.req_val[int'(pick_idx)*WIDTH +: WIDTH];
                cnt     <= (dur_w == '0) ? DURW'(1) : dur_w;
                owner_q <= pick_idx;
                ptr     <= (pick_idx == OW'(NREQ - 1)) ? '0 : pick_idx + OW'(1);
            end else if (state == FORCE) begin
                cnt <= cnt - DURW'(1);
            end
        end
    end

    // base register keeps tracking its writes even while overridden
    always_ff @(posedge clk) begin
        if (rst)              base_r <= '0;
        else if (bus.base_we) base_r <= bus.base_d;
    end

    // outputs decode only from registers
    always_comb begin
        bus.forced = (state == FORCE);
        bus.busy   = (state != IDLE);
        bus.out    = (state == FORCE) ? val_q : base_r;
        bus.base_q = base_r;
        bus.gnt    = gnt_q;
        bus.owner  = owner_q;
    end
endmodule

// File: tb/tb_force_sched.sv
// tb_force_sched: directed plus random stimulus against a cycle-timeline reference model
module tb_force_sched;
    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int D    = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    force_sched_if #(.NREQ(NREQ), .WIDTH(W), .DURW(D)) bus ();

    force_sched #(.NREQ(NREQ), .WIDTH(W), .DURW(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // model: absolute edge count, grant windows expressed as edge-number ranges
    int       cyc    = 0;
    int       m_free = 0;
    int       m_fend = -1;
    int       m_ptr  = 0;
    int       m_own  = 0;
    logic [3:0] m_base = '0;
    logic [3:0] m_val  = '0;
    logic [3:0] m_gnt  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        logic [3:0]  r, bd;
        logic [15:0] rv, rd;
        logic        we, rs, found;
        int          win, dur;
        logic        f_e;
        r  = bus.req;
        rv = bus.req_val;
        rd = bus.req_dur;
        bd = bus.base_d;
        we = bus.base_we;
        rs = rst;
        @(posedge clk);
        cyc++;
        m_gnt = '0;
        if (rs) begin
            m_free = cyc + 1;
            m_fend = -1;
            m_ptr  = 0;
            m_own  = 0;
            m_base = '0;
            m_val  = '0;
        end else begin
            if (we) m_base = bd;
            if (cyc >= m_free && r != '0) begin
                found = 1'b0;
                win   = 0;
                for (int k = 0; k < NREQ; k++) begin
                    if (!found && r[(m_ptr + k) % NREQ]) begin
                        found = 1'b1;
                        win   = (m_ptr + k) % NREQ;
                    end
                end
                dur = int'(rd[win*D +: D]);
                if (dur == 0) dur = 1;
                m_val  = rv[win*W +: W];
                m_gnt  = 4'(1 << win);
                m_own  = win;
                m_ptr  = (win + 1) % NREQ;
                m_fend = cyc + dur - 1;
                m_free = cyc + dur + 2;
            end
        end
        #1;
        f_e = (cyc <= m_fend);
        chk("gnt",    32'(bus.gnt),    32'(m_gnt));
        chk("forced", 32'(bus.forced), 32'(f_e));
        chk("out",    32'(bus.out),    32'(f_e ? m_val : m_base));
        chk("owner",  32'(bus.owner),  32'(m_own));
        chk("busy",   32'(bus.busy),   32'(cyc < m_free - 1));
        chk("base_q", 32'(bus.base_q), 32'(m_base));
    endtask

    int g_cyc[$];
    int g_own[$];

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.req_val = '0;
        bus.req_dur = '0;
        bus.base_d  = '0;
        bus.base_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        bus.base_d  = 4'h1;
        bus.base_we = 1'b1;
        tick();
        bus.base_we = 1'b0;
        chk("base_out", 32'(bus.out), 32'h1);

        bus.req[2]         = 1'b1;
        bus.req_val[8 +: 4] = 4'h3;
        bus.req_dur[8 +: 4] = 4'd3;
        tick();
        chk("gnt2", 32'(bus.gnt), 32'b0100);
        chk("own2", 32'(bus.owner), 32'd2);
        bus.req     = '0;
        bus.base_d  = 4'h2;
        bus.base_we = 1'b1;
        tick();
        bus.base_we = 1'b0;
        chk("under_base", 32'(bus.base_q), 32'h2);
        chk("under_out", 32'(bus.out), 32'h3);
        tick();
        chk("last_force", 32'(bus.out), 32'h3);
        tick();
        chk("gap_out", 32'(bus.out), 32'h2);
        chk("gap_forced", 32'(bus.forced), 32'h0);
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req     = 4'hf;
        bus.req_dur = 16'h1111;
        bus.req_val = 16'h8765;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.gnt != '0) begin
                g_cyc.push_back(cyc);
                g_own.push_back(int'(bus.owner));
            end
        end
        bus.req = '0;
        chk("rr_count", 32'(g_own.size()), 32'd5);
        for (int i = 0; i < g_own.size(); i++) begin
            chk("rr_order", 32'(g_own[i]), 32'(i % NREQ));
            if (i > 0) chk("rr_space", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
        end
        repeat (3) tick();

        bus.req[1]          = 1'b1;
        bus.req_val[4 +: 4] = 4'h9;
        bus.req_dur[4 +: 4] = 4'd0;
        tick();
        bus.req = '0;
        chk("dur0_on", 32'(bus.forced), 32'h1);
        tick();
        chk("dur0_off", 32'(bus.forced), 32'h0);
        repeat (2) tick();

        bus.req[2]          = 1'b1;
        bus.req_dur[8 +: 4] = 4'd5;
        tick();
        bus.req = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_forced", 32'(bus.forced), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        rst         = 1'b0;
        bus.req     = 4'b1001;
        tick();
        chk("rst_ptr", 32'(bus.owner), 32'd0);
        chk("rst_gnt", 32'(bus.gnt), 32'b0001);
        bus.req = '0;
        repeat (6) tick();

        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 49) == 0);
            bus.req     = 4'($urandom_range(0, 15));
            bus.req_val = 16'($urandom);
            for (int k = 0; k < NREQ; k++) bus.req_dur[k*D +: D] = 4'($urandom_range(0, 4));
            bus.base_d  = 4'($urandom);
            bus.base_we = $urandom_range(0, 1) == 1;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
